nvme_cq_poller: RTL and testbench
=================================

// Module: nvme_cq_poller
// PURPOSE
//  Parametrised NVMe completion-queue poller for one I/O queue pair; successor to the fixed 16-entry write-CQ handler.
//  Polls host-memory CQ entries over AXI read and tracks cq_head and phase; streams completions (cid, status, sqhead) out with backpressure.
//  Coalesces CQ-head doorbell writes (every DB_BATCH entries, or when drained) and polls only while commands are outstanding.
//  Sits between the SQ submit path (issue pulses) and the NVMe controller AXI master port.
// PARAMETERS
//  ADDR_WIDTH  32            AXI address width (cq_ar, db_aw)
//  DATA_WIDTH  128           AXI data width; fixed at 128 (one 16B CQE per beat)
//  QDEPTH      16            CQ/SQ entries; power of 2, >=2
//  CQ_BASE     518*1024*1024 byte address of CQ entry 0
//  DB_ADDR     1012          CQ head doorbell byte address (4B register)
//  DB_BATCH    4             completions per doorbell write; 1..QDEPTH-1
//  POLL_GAP    8             idle cycles after an empty poll before the next AR; 0 = back-to-back
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous active-high reset
//  issue        in   1    one command submitted this cycle (pulse)
//  cq_araddr    out  ADDR_WIDTH  CQ_BASE + cq_head*16
//  cq_arlen/arsize/arburst  out  8/3/2  constant 0 / 4 / 1 (INCR)
//  cq_arvalid   out  1    read request valid
//  cq_arready   in   1    read request ready
//  cq_rdata     in   128  CQE: [64+:16] sqhead, [96+:16] cid, [112] phase, [113+:15] status
//  cq_rresp     in   2    read response
//  cq_rvalid    in   1    read data valid
//  cq_rready    out  1    read data ready
//  db_awaddr    out  ADDR_WIDTH  DB_ADDR
//  db_awlen/awsize/awburst  out  8/3/2  constant 0 / 2 / 1
//  db_awvalid/db_awready    out/in  1   doorbell address handshake
//  db_wdata     out  128  {96'b0, cq_head} << (8*DB_ADDR[3:0])
//  db_wstrb     out  16   16'h000F << DB_ADDR[3:0]
//  db_wlast     out  1    constant 1
//  db_wvalid/db_wready      out/in  1   doorbell data handshake
//  db_bresp/db_bvalid/db_bready  in/in/out  2/1/1  doorbell response
//  cpl_valid/cpl_ready      out/in  1   completion stream handshake
//  cpl_cid      out  16   command identifier
//  cpl_status   out  15   CQE status field (0 = success)
//  sq_head      out  $clog2(QDEPTH)  last sqhead reported by the controller
//  outstanding  out  $clog2(QDEPTH)+1  commands issued, not yet completed
//  err          out  1    sticky error flag
// BEHAVIOUR
//  Reset: all *valid outputs 0; cq_rready and db_bready 0; cq_head, sq_head, outstanding, pending and err all 0; phase 1; state IDLE.
//  FSM states: IDLE, AR, R, GAP, EMIT, DB, DB_B.
//  IDLE   -> AR when outstanding != 0.
//  AR     -> assert cq_arvalid; go to R on handshake.
//  R      -> assert cq_rready.
//    rresp != 0: set err, discard the beat, go to AR.
//    rdata[112] != phase: entry empty; go to GAP (POLL_GAP > 0) or AR.
//    Otherwise latch the CQE and go to EMIT.
//  GAP    -> count POLL_GAP cycles, then go to AR.
//  EMIT   -> present cpl_*; hold values stable until cpl_ready. On handshake:
//    cq_head++ (wraps QDEPTH-1 -> 0; phase toggles on wrap); sq_head <= sqhead[$clog2(QDEPTH)-1:0]; outstanding--; pending++.
//    Next state: DB if (pending+1 == DB_BATCH) or (outstanding-1 == 0); else AR.
//  DB     -> drive aw and w in parallel, with a per-channel done flag so each handshakes exactly once.
//    Both done: clear pending, go to DB_B.
//    db_wdata is sampled from the cq_head value after the increment.
//  DB_B   -> assert db_bready. On bvalid: set err if bresp != 0; go to AR if outstanding != 0, else IDLE.
//  outstanding: issue and EMIT-handshake in the same cycle -> net unchanged.
//    issue when outstanding == QDEPTH-1 and no completion in that cycle: ignored, err set.
//  issue is accepted in every state.
//  Only one AXI read or write is in flight at any time; no IDs are needed.
//  rlast is ignored; single-beat reads only.
//  rst is honoured in any state and abandons in-flight AXI transactions; the system resets both sides together.
// STRUCTURE
//  Shared package nvme_pkg: CQE field offsets, AXI burst/size constants, a cqe_t struct, and the poller state enum.
//  Sub-module nvme_db_writer: single-shot AW+W+B writer with block flags, used by state DB; reusable by the SQ doorbell path.
// TESTING
//  1 issue x1; CQE[0] has phase=1, cid=7, sqhead=1 -> one AR at CQ_BASE; cpl cid=7, status=0; db_wdata lane = 1; outstanding 0; state IDLE.
//  2 issue x4, DB_BATCH=4; four valid CQEs -> four cpl beats; exactly one doorbell with value 4; no AR once outstanding reaches 0.
//  3 Empty CQE (phase=0), POLL_GAP=8 -> next cq_arvalid rises no earlier than 8 cycles after the R handshake; then a valid CQE completes normally.
//  4 QDEPTH=16: complete 17 entries across the wrap -> araddr returns to CQ_BASE; phase 0 is expected after the wrap; doorbell value 1 after the 17th.
//  5 cpl_ready held low 20 cycles during EMIT -> cpl_* stable; no new AR; issue pulses still counted.
//  6 cq_rresp=2'b10 on a poll -> err=1; the AR is retried at the same address. rst pulsed mid-DB -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/nvme_pkg.sv
// nvme_pkg: shared definitions for the NVMe completion-queue poller and
// its doorbell writer. CQE layout, AXI encodings, poller states and helpers.
package nvme_pkg;

    // The interesting CQE dwords (DW2, DW3) occupy the upper half of the 16B beat.
    localparam int CQE_HI_LSB = 64;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    localparam logic [2:0] AXI_SIZE_16B   = 3'd4;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Upper 64 bits of a completion queue entry, MSB first.
    typedef struct packed {
        logic [14:0] status;   // [113+:15]
        logic        phase;    // [112]
        logic [15:0] cid;      // [96+:16]
        logic [15:0] sqid;     // [80+:16]
        logic [15:0] sqhead;   // [64+:16]
    } cqe_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_GAP,
        ST_EMIT,
        ST_DB,
        ST_DB_B
    } poller_state_t;

    // Place a 32-bit doorbell value in its byte lane of a 128-bit beat.
    function automatic logic [127:0] db_lane_data(input logic [31:0] value,
                                                 input logic [3:0]  byte_off);
        logic [127:0] v;
        v = {96'b0, value};
        return v << {byte_off, 3'b000};
    endfunction

    // Byte strobes covering the 4B doorbell register.
    function automatic logic [15:0] db_lane_strb(input logic [3:0] byte_off);
        return 16'h000F << byte_off;
    endfunction

endpackage

// File: rtl/nvme_db_writer.sv
// nvme_db_writer: single-shot AXI write (AW + W in parallel, then B).
// Handshakes: a transfer happens on a channel in a cycle where valid and
// ready are both high; valid, once raised, stays high with stable payload
// until that cycle.
module nvme_db_writer
    import nvme_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    send,
    input  logic                    collect,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [ADDR_WIDTH-1:0]   db_awaddr,
    output logic [7:0]              db_awlen,
    output logic [2:0]              db_awsize,
    output logic [1:0]              db_awburst,
    output logic                    db_awvalid,
    input  logic                    db_awready,
    output logic [DATA_WIDTH-1:0]   db_wdata,
    output logic [DATA_WIDTH/8-1:0] db_wstrb,
    output logic                    db_wlast,
    output logic                    db_wvalid,
    input  logic                    db_wready,
    input  logic [1:0]              db_bresp,
    input  logic                    db_bvalid,
    output logic                    db_bready,
    output logic                    sent,
    output logic                    resp_done,
    output logic                    resp_err
);

    logic aw_done;
    logic w_done;
    logic aw_fire;
    logic w_fire;

    assign db_awaddr  = addr;
    assign db_awlen   = 8'd0;
    assign db_awsize  = AXI_SIZE_4B;
    assign db_awburst = AXI_BURST_INCR;
    assign db_awvalid = send && !aw_done;
    assign db_wdata   = data;
    assign db_wstrb   = strb;
    assign db_wlast   = 1'b1;
    assign db_wvalid  = send && !w_done;

    assign aw_fire   = db_awvalid && db_awready;
    assign w_fire    = db_wvalid && db_wready;
    assign sent      = send && (aw_done || aw_fire) && (w_done || w_fire);
    assign db_bready = collect;
    assign resp_done = collect && db_bvalid;
    assign resp_err  = resp_done && (db_bresp != AXI_RESP_OKAY);

    // Remember which channel already handshook so neither is sent twice.
    always_ff @(posedge clk) begin
        if (rst || sent) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
        end
    end

endmodule

// File: rtl/nvme_cq_poller.sv
// nvme_cq_poller: polls one NVMe completion queue over AXI read, streams
// completions out and writes the CQ head doorbell in batches.
// Handshakes: every valid/ready pair transfers in a cycle where both are
// high; a raised valid holds with a stable payload until that cycle.
module nvme_cq_poller
    import nvme_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 128,
    parameter int                    QDEPTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] CQ_BASE    = ADDR_WIDTH'(518*1024*1024),
    parameter logic [ADDR_WIDTH-1:0] DB_ADDR    = ADDR_WIDTH'(1012),
    parameter int                    DB_BATCH   = 4,
    parameter int                    POLL_GAP   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    output logic [ADDR_WIDTH-1:0]      cq_araddr,
    output logic [7:0]                 cq_arlen,
    output logic [2:0]                 cq_arsize,
    output logic [1:0]                 cq_arburst,
    output logic                       cq_arvalid,
    input  logic                       cq_arready,
    input  logic [DATA_WIDTH-1:0]      cq_rdata,
    input  logic [1:0]                 cq_rresp,
    input  logic                       cq_rvalid,
    output logic                       cq_rready,
    output logic [ADDR_WIDTH-1:0]      db_awaddr,
    output logic [7:0]                 db_awlen,
    output logic [2:0]                 db_awsize,
    output logic [1:0]                 db_awburst,
    output logic                       db_awvalid,
    input  logic                       db_awready,
    output logic [DATA_WIDTH-1:0]      db_wdata,
    output logic [DATA_WIDTH/8-1:0]    db_wstrb,
    output logic                       db_wlast,
    output logic                       db_wvalid,
    input  logic                       db_wready,
    input  logic [1:0]                 db_bresp,
    input  logic                       db_bvalid,
    output logic                       db_bready,
    output logic                       cpl_valid,
    input  logic                       cpl_ready,
    output logic [15:0]                cpl_cid,
    output logic [14:0]                cpl_status,
    output logic [$clog2(QDEPTH)-1:0]  sq_head,
    output logic [$clog2(QDEPTH):0]    outstanding,
    output logic                       err,
    output poller_state_t              state
);

    localparam int            IW       = $clog2(QDEPTH);
    localparam int            GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [IW:0]   ONE_W    = (IW+1)'(1);
    localparam logic [IW:0]   OUT_MAX  = (IW+1)'(QDEPTH-1);
    localparam logic [IW:0]   BATCH    = (IW+1)'(DB_BATCH);
    localparam logic [IW-1:0] HEAD_MAX = IW'(QDEPTH-1);
    localparam logic [GW-1:0] GAP_LOAD = (POLL_GAP > 0) ? GW'(POLL_GAP-1) : '0;

    logic [IW-1:0]         cq_head;
    logic                  phase;
    logic [IW:0]           pending;
    logic [IW-1:0]         cqe_sqhead;
    logic [GW-1:0]         gap_cnt;
    cqe_t                  rx_cqe;
    logic                  rx_unused;
    logic                  emit_fire;
    logic                  db_sent;
    logic                  db_resp_done;
    logic                  db_resp_err;
    logic [DATA_WIDTH-1:0] db_data;

    assign rx_cqe    = cqe_t'(cq_rdata[CQE_HI_LSB +: 64]);
    assign rx_unused = ^{cq_rdata[CQE_HI_LSB-1:0], rx_cqe.sqid, rx_cqe.sqhead[15:IW]};

    assign cq_araddr  = CQ_BASE + ADDR_WIDTH'({cq_head, 4'b0000});
    assign cq_arlen   = 8'd0;
    assign cq_arsize  = AXI_SIZE_16B;
    assign cq_arburst = AXI_BURST_INCR;
    assign cq_arvalid = (state == ST_AR);
    assign cq_rready  = (state == ST_R);
    assign cpl_valid  = (state == ST_EMIT);
    assign emit_fire  = cpl_valid && cpl_ready;
    // cq_head has already advanced past the last emitted entry in ST_DB.
    assign db_data    = db_lane_data(32'(cq_head), DB_ADDR[3:0]);

    nvme_db_writer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_db_writer (
        .clk        (clk),
        .rst        (rst),
        .send       (state == ST_DB),
        .collect    (state == ST_DB_B),
        .addr       (DB_ADDR),
        .data       (db_data),
        .strb       (db_lane_strb(DB_ADDR[3:0])),
        .db_awaddr  (db_awaddr),
        .db_awlen   (db_awlen),
        .db_awsize  (db_awsize),
        .db_awburst (db_awburst),
        .db_awvalid (db_awvalid),
        .db_awready (db_awready),
        .db_wdata   (db_wdata),
        .db_wstrb   (db_wstrb),
        .db_wlast   (db_wlast),
        .db_wvalid  (db_wvalid),
        .db_wready  (db_wready),
        .db_bresp   (db_bresp),
        .db_bvalid  (db_bvalid),
        .db_bready  (db_bready),
        .sent       (db_sent),
        .resp_done  (db_resp_done),
        .resp_err   (db_resp_err)
    );

    // Poll/emit/doorbell sequencing plus outstanding-command accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cq_head     <= '0;
            phase       <= 1'b1;
            pending     <= '0;
            sq_head     <= '0;
            outstanding <= '0;
            err         <= 1'b0;
            gap_cnt     <= '0;
            cpl_cid     <= '0;
            cpl_status  <= '0;
            cqe_sqhead  <= '0;
        end else begin
            // An issue and a completion in the same cycle cancel out.
            if (issue && !emit_fire) begin
                if (outstanding == OUT_MAX) err <= 1'b1;
                else                        outstanding <= outstanding + ONE_W;
            end else if (!issue && emit_fire) begin
                outstanding <= outstanding - ONE_W;
            end

            case (state)
                ST_IDLE: if (outstanding != '0) state <= ST_AR;
                ST_AR:   if (cq_arready) state <= ST_R;
                ST_R: if (cq_rvalid) begin
                    if (cq_rresp != AXI_RESP_OKAY) begin
                        err   <= 1'b1;
                        state <= ST_AR;
                    end else if (rx_cqe.phase != phase) begin
                        if (POLL_GAP > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end else begin
                            state <= ST_AR;
                        end
                    end else begin
                        cpl_cid    <= rx_cqe.cid;
                        cpl_status <= rx_cqe.status;
                        cqe_sqhead <= rx_cqe.sqhead[IW-1:0];
                        state      <= ST_EMIT;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) state <= ST_AR;
                    else               gap_cnt <= gap_cnt - GW'(1);
                end
                ST_EMIT: if (cpl_ready) begin
                    cq_head <= cq_head + IW'(1);
                    if (cq_head == HEAD_MAX) phase <= ~phase;
                    sq_head <= cqe_sqhead;
                    pending <= pending + ONE_W;
                    if ((pending + ONE_W) == BATCH || outstanding == ONE_W) state <= ST_DB;
                    else                                                   state <= ST_AR;
                end
                ST_DB: if (db_sent) begin
                    pending <= '0;
                    state   <= ST_DB_B;
                end
                ST_DB_B: if (db_resp_done) begin
                    if (db_resp_err) err <= 1'b1;
                    state <= (outstanding != '0) ? ST_AR : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nvme_cq_poller.sv
// tb_nvme_cq_poller: directed scenarios against a host-memory CQ model and a
// doorbell slave; expected completions and doorbell values go into queues
// and a negedge monitor pops and compares them.
module tb_nvme_cq_poller;
    import nvme_pkg::*;

    localparam int          QDEPTH  = 16;
    localparam logic [31:0] CQ_BASE = 32'h2060_0000;   // 518 MiB
    localparam logic [31:0] DB_ADDR = 32'd1012;
    localparam int          DB_LANE = 32;              // 1012 mod 16 = byte 4
    localparam logic [15:0] DB_STRB = 16'h00F0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          issue = 1'b0;
    logic [31:0]   cq_araddr;
    logic [7:0]    cq_arlen;
    logic [2:0]    cq_arsize;
    logic [1:0]    cq_arburst;
    logic          cq_arvalid;
    logic          cq_arready = 1'b1;
    logic [127:0]  cq_rdata;
    logic [1:0]    cq_rresp;
    logic          cq_rvalid;
    logic          cq_rready;
    logic [31:0]   db_awaddr;
    logic [7:0]    db_awlen;
    logic [2:0]    db_awsize;
    logic [1:0]    db_awburst;
    logic          db_awvalid;
    logic          db_awready = 1'b1;
    logic [127:0]  db_wdata;
    logic [15:0]   db_wstrb;
    logic          db_wlast;
    logic          db_wvalid;
    logic          db_wready = 1'b1;
    logic [1:0]    db_bresp = 2'b00;
    logic          db_bvalid;
    logic          db_bready;
    logic          cpl_valid;
    logic          cpl_ready = 1'b1;
    logic [15:0]   cpl_cid;
    logic [14:0]   cpl_status;
    logic [3:0]    sq_head;
    logic [4:0]    outstanding;
    logic          err;
    poller_state_t state;

    nvme_cq_poller #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (128),
        .QDEPTH     (QDEPTH),
        .CQ_BASE    (CQ_BASE),
        .DB_ADDR    (DB_ADDR),
        .DB_BATCH   (4),
        .POLL_GAP   (8)
    ) dut (
        .clk(clk), .rst(rst), .issue(issue),
        .cq_araddr(cq_araddr), .cq_arlen(cq_arlen), .cq_arsize(cq_arsize),
        .cq_arburst(cq_arburst), .cq_arvalid(cq_arvalid), .cq_arready(cq_arready),
        .cq_rdata(cq_rdata), .cq_rresp(cq_rresp), .cq_rvalid(cq_rvalid), .cq_rready(cq_rready),
        .db_awaddr(db_awaddr), .db_awlen(db_awlen), .db_awsize(db_awsize),
        .db_awburst(db_awburst), .db_awvalid(db_awvalid), .db_awready(db_awready),
        .db_wdata(db_wdata), .db_wstrb(db_wstrb), .db_wlast(db_wlast),
        .db_wvalid(db_wvalid), .db_wready(db_wready),
        .db_bresp(db_bresp), .db_bvalid(db_bvalid), .db_bready(db_bready),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_cid(cpl_cid),
        .cpl_status(cpl_status), .sq_head(sq_head), .outstanding(outstanding),
        .err(err), .state(state)
    );

    // ---------------- scoreboard state ----------------
    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [30:0]  exp_q[$];      // {cid, status}
    logic [31:0]  exp_db_q[$];   // doorbell head values
    logic [127:0] mem [QDEPTH];
    int           wr_idx;
    logic         wr_phase;
    int           ar_count;
    int           rerr_at = -1;
    int           cyc = 0;
    int           last_r_cyc = 0;
    int           ar_gap = 0;
    logic         prev_ar = 1'b0;
    int           exp_head = 0;
    int           cpl_count = 0;
    logic         aw_got, w_got;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [127:0] make_cqe(input logic [15:0] cid, input logic [14:0] status,
                                             input logic [15:0] sqhead, input logic ph);
        logic [127:0] d;
        d = '0;
        d[64 +: 16]  = sqhead;
        d[96 +: 16]  = cid;
        d[112]       = ph;
        d[113 +: 15] = status;
        return d;
    endfunction

    function automatic logic [3:0] slot_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - CQ_BASE) >> 4;
        return off[3:0];
    endfunction

    // ---------------- host memory / AXI read slave ----------------
    always @(posedge clk) begin
        if (rst) begin
            cq_rvalid <= 1'b0;
            cq_rdata  <= '0;
            cq_rresp  <= 2'b00;
            ar_count  <= 0;
        end else begin
            if (cq_rvalid && cq_rready) cq_rvalid <= 1'b0;
            if (cq_arvalid && cq_arready) begin
                cq_rvalid <= 1'b1;
                cq_rdata  <= mem[slot_of(cq_araddr)];
                cq_rresp  <= (ar_count == rerr_at) ? 2'b10 : 2'b00;
                ar_count  <= ar_count + 1;
            end
        end
    end

    // ---------------- doorbell write slave ----------------
    always @(posedge clk) begin
        if (rst) begin
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            db_bvalid <= 1'b0;
        end else begin
            if (db_awvalid && db_awready) aw_got <= 1'b1;
            if (db_wvalid && db_wready)   w_got  <= 1'b1;
            if (db_bvalid && db_bready) begin
                db_bvalid <= 1'b0;
            end else if (aw_got && w_got && !db_bvalid) begin
                db_bvalid <= 1'b1;
                aw_got    <= 1'b0;
                w_got     <= 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [30:0] e;
        logic [31:0] a;
        cyc++;
        if (rst) begin
            exp_head = 0;
            prev_ar  = 1'b0;
        end else begin
            if (cq_arvalid && !prev_ar) ar_gap = cyc - last_r_cyc;
            prev_ar = cq_arvalid;
            if (cq_arvalid && cq_arready) begin
                a = CQ_BASE + 32'(exp_head * 16);
                check("ar_addr", cq_araddr, a);
                check("ar_len_size_burst", {cq_arlen, cq_arsize, cq_arburst}, {8'd0, 3'd4, 2'd1});
            end
            if (cq_rvalid && cq_rready) last_r_cyc = cyc;
            if (cpl_valid && cpl_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("cpl_unexpected", $sformatf("cid %0h with nothing expected", cpl_cid));
                end else begin
                    e = exp_q.pop_front();
                    check("cpl_cid", cpl_cid, e[30:15]);
                    check("cpl_status", cpl_status, e[14:0]);
                end
                exp_head = (exp_head + 1) % QDEPTH;
                cpl_count++;
            end
            if (db_awvalid && db_awready) begin
                check("db_awaddr", db_awaddr, DB_ADDR);
                check("db_aw_len_size_burst", {db_awlen, db_awsize, db_awburst}, {8'd0, 3'd2, 2'd1});
            end
            if (db_wvalid && db_wready) begin
                check("db_wstrb", db_wstrb, DB_STRB);
                check("db_wlast", db_wlast, 1'b1);
                if (exp_db_q.size() == 0)
                    fail_now("db_unexpected", $sformatf("value %0h", db_wdata[DB_LANE +: 32]));
                else
                    check("db_value", db_wdata[DB_LANE +: 32], exp_db_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_model();
        for (int i = 0; i < QDEPTH; i++) mem[i] = '0;
        wr_idx   = 0;
        wr_phase = 1'b1;
        exp_q.delete();
        exp_db_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        issue = 1'b0;
        repeat (2) @(negedge clk);
        clear_model();
        rst = 1'b0;
    endtask

    task automatic post_cqe(input logic [15:0] cid, input logic [14:0] status, input logic [15:0] sqh);
        mem[wr_idx] = make_cqe(cid, status, sqh, wr_phase);
        exp_q.push_back({cid, status});
        wr_idx++;
        if (wr_idx == QDEPTH) begin
            wr_idx   = 0;
            wr_phase = ~wr_phase;
        end
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            issue = 1'b1;
            @(negedge clk);
        end
        issue = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0 && exp_db_q.size() == 0 && outstanding == 0 && state == ST_IDLE) break;
            @(negedge clk);
        end
        if (i == 1000) fail_now(name, $sformatf("no drain, %0d cpl / %0d db left", exp_q.size(), exp_db_q.size()));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_arvalid"}, cq_arvalid, 1'b0);
        check({tag, "_rready"}, cq_rready, 1'b0);
        check({tag, "_awvalid"}, db_awvalid, 1'b0);
        check({tag, "_wvalid"}, db_wvalid, 1'b0);
        check({tag, "_bready"}, db_bready, 1'b0);
        check({tag, "_cpl_valid"}, cpl_valid, 1'b0);
        check({tag, "_outstanding"}, outstanding, 5'd0);
        check({tag, "_sq_head"}, sq_head, 4'd0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_state"}, state, ST_IDLE);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int arc;
        int cc;
        int i;
        logic [15:0] held_cid;
        logic [14:0] held_status;

        clear_model();
        do_reset();
        check_reset_values("reset");

        // 1: single command, single CQE, drained doorbell
        post_cqe(16'd7, 15'd0, 16'd1);
        exp_db_q.push_back(32'd1);
        issue_n(1);
        wait_drain("t1_drain");
        check("t1_sq_head", sq_head, 4'd1);
        check("t1_outstanding", outstanding, 5'd0);
        check("t1_state", state, ST_IDLE);
        check("t1_ar_count", ar_count, 1);

        // 2: four commands, one batched doorbell, no polling once drained
        do_reset();
        for (int k = 0; k < 4; k++) post_cqe(16'(10 + k), 15'd0, 16'(k + 1));
        exp_db_q.push_back(32'd4);
        issue_n(4);
        wait_drain("t2_drain");
        arc = ar_count;
        repeat (30) @(negedge clk);
        check("t2_no_idle_ar", ar_count, arc);
        check("t2_ar_count", ar_count, 4);
        check("t2_sq_head", sq_head, 4'd4);

        // 3: empty poll then back-off before the next read
        do_reset();
        issue_n(1);
        for (i = 0; i < 200; i++) begin
            if (ar_count >= 2) break;
            @(negedge clk);
        end
        if (i == 200) fail_now("t3_second_ar", "second poll never issued");
        n_cmp++;
        if (ar_gap < 8) begin
            n_fail++;
            $display("FAIL t3_poll_gap: got %0d cycles, required at least 8", ar_gap);
        end
        post_cqe(16'h0055, 15'h0002, 16'd3);
        exp_db_q.push_back(32'd1);
        wait_drain("t3_drain");
        check("t3_sq_head", sq_head, 4'd3);

        // 4: seventeen completions across the queue wrap
        do_reset();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) post_cqe(16'(100 + b*4 + k), 15'(k), 16'(b*4 + k));
            exp_db_q.push_back(32'(((b + 1) * 4) % QDEPTH));
            issue_n(4);
            wait_drain("t4_batch_drain");
        end
        cc = cpl_count;
        issue_n(1);
        repeat (20) @(negedge clk);
        check("t4_stale_entry_ignored", cpl_count, cc);
        post_cqe(16'd200, 15'd0, 16'd5);
        exp_db_q.push_back(32'd1);
        wait_drain("t4_wrap_drain");
        check("t4_sq_head", sq_head, 4'd5);

        // 5: completion backpressure with issues arriving meanwhile
        do_reset();
        for (int k = 0; k < 3; k++) post_cqe(16'(300 + k), 15'(k + 1), 16'(k + 7));
        exp_db_q.push_back(32'd3);
        cpl_ready = 1'b0;
        issue_n(1);
        for (i = 0; i < 100; i++) begin
            if (cpl_valid) break;
            @(negedge clk);
        end
        check("t5_cpl_presented", cpl_valid, 1'b1);
        held_cid    = cpl_cid;
        held_status = cpl_status;
        arc         = ar_count;
        for (int k = 0; k < 20; k++) begin
            issue = (k == 3 || k == 9);
            @(negedge clk);
            check("t5_cid_stable", cpl_cid, held_cid);
            check("t5_status_stable", cpl_status, held_status);
        end
        issue = 1'b0;
        check("t5_cid_value", held_cid, 16'd300);
        check("t5_no_ar_while_held", ar_count, arc);
        check("t5_outstanding", outstanding, 5'd3);
        cpl_ready = 1'b1;
        wait_drain("t5_drain");
        check("t5_sq_head", sq_head, 4'd9);

        // 6: read error retried at the same address, then reset mid-doorbell
        do_reset();
        rerr_at = 0;
        post_cqe(16'h0066, 15'd0, 16'd2);
        exp_db_q.push_back(32'd1);
        issue_n(1);
        wait_drain("t6_drain");
        rerr_at = -1;
        check("t6_err", err, 1'b1);
        check("t6_ar_retry_count", ar_count, 2);

        db_awready = 1'b0;
        db_wready  = 1'b0;
        post_cqe(16'h0077, 15'd0, 16'd3);
        issue_n(1);
        for (i = 0; i < 100; i++) begin
            if (state == ST_DB) break;
            @(negedge clk);
        end
        check("t6_reached_db", state, ST_DB);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("t6_rst_mid_db");
        clear_model();
        rst        = 1'b0;
        db_awready = 1'b1;
        db_wready  = 1'b1;
        @(negedge clk);
        post_cqe(16'h0088, 15'd0, 16'd1);
        exp_db_q.push_back(32'd1);
        issue_n(1);
        wait_drain("t6_post_reset_drain");
        check("t6_post_reset_err", err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
